// File: rtl/vec_log_pkg.sv
// Shared types and record layout for vec_resp_logger.
// LOGGER_CHECK_EN appends a response-mismatch bit at the record LSB.
package vec_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_e;

`ifdef LOGGER_CHECK_EN
    localparam int unsigned CHK_W = 1;
`else
    localparam int unsigned CHK_W = 0;
`endif

    localparam int unsigned MISM_POS = 0;

    function automatic int unsigned rec_w(input int unsigned idx_w,
                                          input int unsigned vec_w,
                                          input int unsigned resp_w);
        return idx_w + vec_w + resp_w + CHK_W;
    endfunction

    function automatic int unsigned resp_lsb();
        return CHK_W;
    endfunction

    function automatic int unsigned vec_lsb(input int unsigned resp_w);
        return CHK_W + resp_w;
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned vec_w,
                                            input int unsigned resp_w);
        return CHK_W + resp_w + vec_w;
    endfunction

endpackage

// File: rtl/vec_resp_logger_if.sv
// Record stream from the logger to its consumer (valid/ready).
interface vec_resp_logger_if #(
    parameter int unsigned DW = 8
) ();
    logic          rec_valid_o;
    logic          rec_ready_i;
    logic [DW-1:0] rec_data_o;

    modport master (output rec_valid_o, output rec_data_o, input rec_ready_i);
    modport slave  (input rec_valid_o, input rec_data_o, output rec_ready_i);
endinterface

// File: rtl/vec_log_fifo.sv
// Synchronous FIFO, DEPTH a power of two; output read from registered storage.
module vec_log_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         empty_o,
    output logic         full_o,
    output logic         one_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign one_o   = (cnt_q == (AW+1)'(1));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push on full is still taken.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/vec_resp_logger.sv
// Captures {idx, vec, resp} per sample into a FIFO and streams records out.
// LOGGER_CHECK_EN adds exp_i/err_cnt_o and a per-record mismatch bit.
module vec_resp_logger
    import vec_log_pkg::*;
#(
    parameter int unsigned VEC_W   = 3,
    parameter int unsigned RESP_W  = 1,
    parameter int unsigned NUM_VEC = 8,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              sample_i,
    input  logic [VEC_W-1:0]  vec_i,
    input  logic [RESP_W-1:0] resp_i,
`ifdef LOGGER_CHECK_EN
    input  logic [RESP_W-1:0] exp_i,
    output logic [IDX_W:0]    err_cnt_o,
`endif
    vec_resp_logger_if.master rec,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o
);
    localparam int unsigned REC_W    = rec_w(IDX_W, VEC_W, RESP_W);
    localparam int unsigned IDX_LSB  = idx_lsb(VEC_W, RESP_W);
    localparam int unsigned VEC_LSB  = vec_lsb(RESP_W);
    localparam int unsigned RESP_LSB = resp_lsb();
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             push, pop, start_run;
    logic             fifo_empty, fifo_full, fifo_one;
    logic [REC_W-1:0] rec_in;

    assign pop             = rec.rec_valid_o && rec.rec_ready_i;
    assign rec.rec_valid_o = !fifo_empty;

`ifdef LOGGER_CHECK_EN
    logic [IDX_W:0] err_q, err_d;
    logic           mism;
    assign mism      = (resp_i != exp_i);
    assign err_cnt_o = err_q;
`endif

    always_comb begin
        rec_in = '0;
        rec_in[IDX_LSB +: IDX_W]   = idx_q;
        rec_in[VEC_LSB +: VEC_W]   = vec_i;
        rec_in[RESP_LSB +: RESP_W] = resp_i;
`ifdef LOGGER_CHECK_EN
        rec_in[MISM_POS] = mism;
`endif
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        start_run = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_CAPTURE;
                    idx_d     = '0;
                    ovf_d     = 1'b0;
                    start_run = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (sample_i) begin
                    push = 1'b1;
                    if (fifo_full && !pop) ovf_d = 1'b1;
                    if (idx_q == LAST_IDX) state_d = ST_DRAIN;
                    else                   idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                // Leave as the last record transfers so done follows it by one cycle.
                if (fifo_empty || (fifo_one && pop)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef LOGGER_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (start_run)                              err_d = '0;
        else if (push && mism && (err_q != '1))     err_d = err_q + (IDX_W+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end
`endif

    assign busy_o = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign done_o = (state_q == ST_DONE);
    assign ovf_o  = ovf_q;

    vec_log_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (rec_in),
        .pop_i   (pop),
        .data_o  (rec.rec_data_o),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .one_o   (fifo_one)
    );
endmodule

// File: tb/tb_vec_resp_logger.sv
// Directed bench: DUT A (DEPTH 8) and DUT B (DEPTH 4) share stimulus, separate ready.
module tb_vec_resp_logger;
    import vec_log_pkg::*;

    localparam int unsigned DW = rec_w(4, 3, 1);

    typedef struct {
        logic [2:0] vec;
        logic       resp;
        logic       expv;
        logic       start;
        logic [7:0] rec;
        logic       mism;
    } vec_t;

    vec_t tab [8];

    logic       clk = 1'b0;
    logic       rst_n, start, sample;
    logic [2:0] vec;
    logic       resp;
    logic       busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
`ifdef LOGGER_CHECK_EN
    logic       expv;
    logic [4:0] err_a, err_b;
`endif

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;

    logic [DW-1:0] q_a[$];
    logic [DW-1:0] q_b[$];
    int unsigned   tx_a[$];

    vec_resp_logger_if #(.DW(DW)) if_a ();
    vec_resp_logger_if #(.DW(DW)) if_b ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vec_resp_logger #(.VEC_W(3), .RESP_W(1), .NUM_VEC(8), .IDX_W(4), .DEPTH(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .sample_i(sample),
        .vec_i(vec), .resp_i(resp),
`ifdef LOGGER_CHECK_EN
        .exp_i(expv), .err_cnt_o(err_a),
`endif
        .rec(if_a), .busy_o(busy_a), .done_o(done_a), .ovf_o(ovf_a)
    );

    vec_resp_logger #(.VEC_W(3), .RESP_W(1), .NUM_VEC(8), .IDX_W(4), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start), .sample_i(sample),
        .vec_i(vec), .resp_i(resp),
`ifdef LOGGER_CHECK_EN
        .exp_i(expv), .err_cnt_o(err_b),
`endif
        .rec(if_b), .busy_o(busy_b), .done_o(done_b), .ovf_o(ovf_b)
    );

    // Transfers are captured mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (if_a.rec_valid_o && if_a.rec_ready_i) begin
            q_a.push_back(if_a.rec_data_o);
            tx_a.push_back(cyc);
        end
        if (if_b.rec_valid_o && if_b.rec_ready_i) q_b.push_back(if_b.rec_data_o);
    end

    function automatic logic [DW-1:0] exp_rec(input int unsigned i);
`ifdef LOGGER_CHECK_EN
        return {tab[i].rec, tab[i].mism};
`else
        return tab[i].rec;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic r);
        if_a.rec_ready_i = r;
        if_b.rec_ready_i = r;
    endtask

    task automatic apply(input int unsigned i);
        sample = 1'b1;
        vec    = tab[i].vec;
        resp   = tab[i].resp;
        start  = tab[i].start;
`ifdef LOGGER_CHECK_EN
        expv   = tab[i].expv;
`endif
    endtask

    task automatic idle_in();
        sample = 1'b0;
        start  = 1'b0;
    endtask

    task automatic do_start();
        q_a.delete();
        q_b.delete();
        tx_a.delete();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!(done_a && done_b) && n < 200) begin
            tick();
            n++;
        end
        check({name, "_done"}, {31'd0, done_a && done_b}, 32'd1);
    endtask

    task automatic cmp_queue(input string name, input int unsigned n, input logic use_b);
        check({name, "_count"}, use_b ? q_b.size() : q_a.size(), n);
        for (int unsigned i = 0; i < n; i++) begin
            if (i < (use_b ? q_b.size() : q_a.size()))
                check($sformatf("%s_rec[%0d]", name, i), use_b ? q_b[i] : q_a[i], exp_rec(i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned   s0, done_cyc, bad;
        logic [DW-1:0] e;

        // vec, resp(^vec), exp, start, {idx,vec,resp}, mismatch
        tab[0] = '{3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tab[1] = '{3'd1, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0};
        tab[2] = '{3'd2, 1'b1, 1'b0, 1'b0, 8'h25, 1'b1};
        tab[3] = '{3'd3, 1'b0, 1'b0, 1'b0, 8'h36, 1'b0};
        tab[4] = '{3'd4, 1'b1, 1'b1, 1'b1, 8'h49, 1'b0};
        tab[5] = '{3'd5, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1};
        tab[6] = '{3'd6, 1'b0, 1'b0, 1'b0, 8'h6C, 1'b0};
        tab[7] = '{3'd7, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0};

        rst_n = 1'b0; start = 1'b0; sample = 1'b0; vec = '0; resp = 1'b0;
`ifdef LOGGER_CHECK_EN
        expv = 1'b0;
`endif
        set_ready(1'b0);
        tick(); tick(); tick();
        check("rst_valid", {31'd0, if_a.rec_valid_o}, 32'd0);
        check("rst_flags", {28'd0, busy_a, done_a, ovf_a, busy_b}, 32'd0);
        check("rst_data", if_a.rec_data_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Normal run; start pulse on sample 4 must be ignored.
        set_ready(1'b1);
        do_start();
        check("t1_busy", {31'd0, busy_a}, 32'd1);
        s0 = cyc;
        for (int unsigned i = 0; i < 8; i++) begin
            apply(i);
            tick();
        end
        idle_in();
        wait_done("t1");
        done_cyc = cyc;
        cmp_queue("t1_a", 8, 1'b0);
        cmp_queue("t1_b", 8, 1'b1);
        if (tx_a.size() == 8) begin
            check("t1_latency", tx_a[0], s0 + 1);
            check("t1_done_timing", done_cyc, tx_a[7] + 1);
        end else begin
            check("t1_tx_count", tx_a.size(), 32'd8);
        end
        check("t1_ovf", {30'd0, ovf_a, ovf_b}, 32'd0);
`ifdef LOGGER_CHECK_EN
        check("t1_err_a", {27'd0, err_a}, 32'd2);
`endif
        // Sample outside CAPTURE is ignored.
        apply(3);
        start = 1'b0;
        tick();
        idle_in();
        tick(); tick();
        check("t1_ignored_sample", q_a.size(), 32'd8);
        check("t1_still_done", {31'd0, done_a}, 32'd1);

        // Back-pressure on A; overflow on B (DEPTH 4).
        set_ready(1'b0);
        do_start();
`ifdef LOGGER_CHECK_EN
        check("t2_err_cleared", {27'd0, err_a}, 32'd0);
`endif
        for (int unsigned i = 0; i < 8; i++) begin
            apply(i);
            tick();
        end
        idle_in();
        bad = 0;
        for (int unsigned k = 0; k < 12; k++) begin
            if (!if_a.rec_valid_o || (if_a.rec_data_o !== exp_rec(0))) bad++;
            if (!if_b.rec_valid_o || (if_b.rec_data_o !== exp_rec(0))) bad++;
            tick();
        end
        check("t2_hold_stable", bad, 32'd0);
        check("t2_no_xfer", q_a.size(), 32'd0);
        check("t2_busy_a", {31'd0, busy_a}, 32'd1);
        check("t2_ovf_a", {31'd0, ovf_a}, 32'd0);
        check("t2_ovf_b", {31'd0, ovf_b}, 32'd1);
        set_ready(1'b1);
        wait_done("t2");
        cmp_queue("t2_a", 8, 1'b0);
        cmp_queue("t2_b", 4, 1'b1);
        check("t2_ovf_b_sticky", {31'd0, ovf_b}, 32'd1);
`ifdef LOGGER_CHECK_EN
        check("t2_err_b", {27'd0, err_b}, 32'd2);
`endif

        // B full when ready rises together with sample 4: push accepted, no overflow.
        set_ready(1'b0);
        do_start();
        for (int unsigned i = 0; i < 8; i++) begin
            if (i == 4) set_ready(1'b1);
            apply(i);
            tick();
        end
        idle_in();
        wait_done("t3");
        check("t3_ovf_b", {31'd0, ovf_b}, 32'd0);
        cmp_queue("t3_b", 8, 1'b1);

        // Reset mid-CAPTURE after 3 samples.
        set_ready(1'b1);
        do_start();
        for (int unsigned i = 0; i < 3; i++) begin
            apply(i);
            tick();
        end
        idle_in();
        check("t4_pre_valid", {30'd0, if_a.rec_valid_o, busy_a}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_a", {28'd0, if_a.rec_valid_o, busy_a, done_a, ovf_a}, 32'd0);
        check("t4_rst_b", {28'd0, if_b.rec_valid_o, busy_b, done_b, ovf_b}, 32'd0);
        tick();
        rst_n = 1'b1;
        do_start();
        sample = 1'b1; vec = 3'd5; resp = 1'b0;
`ifdef LOGGER_CHECK_EN
        expv = 1'b0;
        e = {8'h0A, 1'b0};
`else
        e = 8'h0A;
`endif
        tick();
        idle_in();
        tick(); tick();
        check("t4_count", q_a.size(), 32'd1);
        if (q_a.size() > 0) check("t4_rec", q_a[0], e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_resp_logger.md
Name: vec_resp_logger

Overview:
- Response-capture end of the stimulus/response bench flow: the stimulus side applies vectors to a DUT; this block records each applied vector with the DUT response it produced.
- Tags every record with a sequence index and buffers it in a FIFO.
- Streams records out over a valid/ready interface to a display/dump agent or serial transmitter.
- Sits beside any combinational or sequential DUT in self-checking benches and on-board test harnesses.

Parameters:
- VEC_W, 3, stimulus vector width
- RESP_W, 1, DUT response width
- NUM_VEC, 8, samples per run (1..2^IDX_W)
- IDX_W, 4, sequence-index width
- DEPTH, 8, FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begins a run (honoured in IDLE and DONE only)
- sample_i  in  1  strobe; capture vec_i/resp_i this cycle
- vec_i  in  VEC_W  applied stimulus vector
- resp_i  in  RESP_W  DUT response
- rec_valid_o  out  1  record available
- rec_ready_i  in  1  consumer accepts record
- rec_data_o  out  IDX_W+VEC_W+RESP_W  {idx, vec, resp}, MSB first
- busy_o  out  1  state is CAPTURE or DRAIN
- done_o  out  1  high in DONE
- ovf_o  out  1  sticky: a sample was dropped on full FIFO

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, idx=0, all outputs 0.
- FSM:
  - IDLE -start_i-> CAPTURE (idx<=0, ovf<=0).
  - CAPTURE: each sample_i pushes {idx, vec_i, resp_i} and idx increments. After the sample with idx==NUM_VEC-1: -> DRAIN. sample_i outside CAPTURE is ignored.
  - DRAIN -FIFO empty-> DONE.
  - DONE: done_o=1; -start_i-> CAPTURE (new run, idx and ovf cleared).
- start_i in CAPTURE/DRAIN is ignored.
- Handshake:
  - Transfer occurs when rec_valid_o && rec_ready_i.
  - rec_data_o stable while valid && !ready.
  - rec_valid_o never drops without a transfer.
- Latency: sample accepted in cycle N -> rec_valid_o in cycle N+1 if FIFO was empty (registered FIFO output); no combinational path from sample_i to outputs.
- Full FIFO:
  - Sample is dropped and ovf_o sets (sticky until next start).
  - idx still increments, so dropped indices show as gaps in the stream.
- Full with simultaneous pop: the pop frees a slot and the push is accepted; no overflow.
- Empty with simultaneous push: no pop; valid rises next cycle.
- idx wraps modulo 2^IDX_W only if NUM_VEC == 2^IDX_W; otherwise it never exceeds NUM_VEC-1.
- Reset mid-run: FIFO contents discarded, back to IDLE.

Optional Feature:
- Macro LOGGER_CHECK_EN.
- Defined: adds port exp_i in RESP_W (expected response) and err_cnt_o out IDX_W+1.
  - Each accepted or dropped sample in CAPTURE with resp_i != exp_i increments err_cnt_o, saturating at all-ones.
  - Cleared on start_i and on reset.
  - Records also carry one extra LSB mismatch bit, so rec_data_o width is +1.
- Undefined: no exp_i or err_cnt_o ports; record format as listed above.

Decomposition:
- Package vec_log_pkg holds:
  - FSM state enum (IDLE, CAPTURE, DRAIN, DONE)
  - record-width localparam function
  - field-position constants for idx/vec/resp/mismatch
- Sub-module vec_log_fifo: synchronous FIFO with parameterised width/DEPTH, registered output, full/empty, simultaneous push/pop.
- Top level holds the FSM, index counter, ovf flag and optional checker.

Test Plan:
- Normal run with default parameters: start, 8 samples vec=0..7, resp=^vec, rec_ready_i=1 -> 8 records {i,i,^i} in order; done_o rises one cycle after the last transfer; ovf_o=0.
- Back-pressure: rec_ready_i=0 for 20 cycles, 8 samples -> all 8 held (DEPTH=8), rec_data_o stable, ovf_o=0; then ready=1 -> 8 records in order.
- Overflow: rec_ready_i=0, DEPTH=4, NUM_VEC=8 -> records idx 0..3 only, ovf_o=1, done_o after drain.
- Full plus simultaneous pop: FIFO full, sample_i and rec_ready_i in the same cycle -> sample stored, ovf_o stays 0.
- Reset mid-CAPTURE after 3 samples: rst_n low -> valid/busy/done/ovf=0 immediately; new start gives idx from 0.
- With LOGGER_CHECK_EN: exp_i=~resp_i for samples 2 and 5 -> err_cnt_o=2; those records have mismatch bit=1.
